// File: rtl/axi_fe_pkg.sv
// rtl/axi_fe_pkg.sv - shared state, burst/response constants and response ranking for the AXI front-end
package axi_fe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_DATA,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_WR_RESP
  } fe_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // DECERR > SLVERR > OKAY; the encodings already sort in that order.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
  import axi_fe_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    // Wrap window spans (len+1) beats; legal WRAP lengths make it a power of two.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_apb_req_frontend.sv
// rtl/axi_apb_req_frontend.sv - AXI slave front-end issuing single-beat requests to the APB master
// WRAP bursts are executed only when AXI_FE_WRAP_EN is defined; otherwise they complete with SLVERR.
module axi_apb_req_frontend
  import axi_fe_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int LEN_WIDTH   = 8,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'h0002_F000, 32'h0001_F000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {32'hFFFF_F000, 32'hFFFF_F000}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [LEN_WIDTH-1:0]    awlen_i,
  input  logic [2:0]              awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [LEN_WIDTH-1:0]    arlen_i,
  input  logic [2:0]              arsize_i,
  input  logic [1:0]              arburst_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic                    req_write_o,
  output logic [ADDR_WIDTH-1:0]   req_addr_o,
  output logic [DATA_WIDTH-1:0]   req_wdata_o,
  output logic [DATA_WIDTH/8-1:0] req_wstrb_o,
  input  logic                    rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]   rsp_rdata_i,
  input  logic                    rsp_err_i
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  fe_state_e state, state_n;

  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    beat_cnt;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [1:0]              err_q;
  logic [1:0]              bresp_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    rvalid_q;
  logic                    bvalid_q;
  logic                    last_wr;

  logic                    ar_gnt, aw_gnt;
  logic [ID_WIDTH-1:0]     in_id;
  logic [ADDR_WIDTH-1:0]   in_addr;
  logic [LEN_WIDTH-1:0]    in_len;
  logic [2:0]              in_size;
  logic [1:0]              in_burst;
  logic [1:0]              in_err;
  logic                    region_hit;
  logic                    burst_ok;
  logic                    is_last;
  logic                    flagged;
  logic [ADDR_WIDTH-1:0]   next_addr;

  assign is_last = (beat_cnt == len_q);
  assign flagged = (err_q != RESP_OKAY);

  // Round-robin on a tie: serve the channel that was not served last.
  always_comb begin
    ar_gnt = 1'b0;
    aw_gnt = 1'b0;
    if (state == ST_IDLE) begin
      ar_gnt = arvalid_i && (!awvalid_i || last_wr);
      aw_gnt = awvalid_i && (!arvalid_i || !last_wr);
    end
  end

  always_comb begin
    in_id    = ar_gnt ? arid_i    : awid_i;
    in_addr  = ar_gnt ? araddr_i  : awaddr_i;
    in_len   = ar_gnt ? arlen_i   : awlen_i;
    in_size  = ar_gnt ? arsize_i  : awsize_i;
    in_burst = ar_gnt ? arburst_i : awburst_i;
    region_hit = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if ((in_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])
        region_hit = 1'b1;
    end
`ifdef AXI_FE_WRAP_EN
    burst_ok = (in_burst != BURST_RSVD) &&
               ((in_burst != BURST_WRAP) ||
                (in_len == LEN_WIDTH'(1)) || (in_len == LEN_WIDTH'(3)) ||
                (in_len == LEN_WIDTH'(7)) || (in_len == LEN_WIDTH'(15)));
`else
    burst_ok = (in_burst != BURST_RSVD) && (in_burst != BURST_WRAP);
`endif
    if (!region_hit)
      in_err = RESP_DECERR;
    else if ((in_size > 3'(MAX_SIZE)) || !burst_ok)
      in_err = RESP_SLVERR;
    else
      in_err = RESP_OKAY;
  end

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    req_valid_o = 1'b0;
    req_write_o = 1'b0;
    wready_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ar_gnt)      state_n = (in_err != RESP_OKAY) ? ST_RD_RESP : ST_RD_REQ;
        else if (aw_gnt) state_n = ST_WR_DATA;
      end
      ST_RD_REQ: begin
        req_valid_o = 1'b1;
        if (req_ready_i) state_n = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (rsp_valid_i) state_n = ST_RD_RESP;
      ST_RD_RESP: begin
        if (rready_i) state_n = is_last ? ST_IDLE : (flagged ? ST_RD_RESP : ST_RD_REQ);
      end
      ST_WR_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) state_n = !flagged ? ST_WR_REQ : (is_last ? ST_WR_RESP : ST_WR_DATA);
      end
      ST_WR_REQ: begin
        req_valid_o = 1'b1;
        req_write_o = 1'b1;
        if (req_ready_i) state_n = ST_WR_WAIT;
      end
      ST_WR_WAIT: if (rsp_valid_i) state_n = is_last ? ST_WR_RESP : ST_WR_DATA;
      ST_WR_RESP: if (bready_i) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      last_wr  <= 1'b1;
    end else begin
      rvalid_q <= (state_n == ST_RD_RESP);
      bvalid_q <= (state_n == ST_WR_RESP);
      case (state)
        ST_IDLE: begin
          if (ar_gnt || aw_gnt) begin
            id_q     <= in_id;
            addr_q   <= in_addr;
            len_q    <= in_len;
            size_q   <= in_size;
            burst_q  <= in_burst;
            err_q    <= in_err;
            beat_cnt <= '0;
            last_wr  <= aw_gnt;
          end
          if (ar_gnt) begin
            rresp_q <= in_err;
            rdata_q <= '0;
          end
          if (aw_gnt) bresp_q <= in_err;
        end
        ST_RD_WAIT: begin
          if (rsp_valid_i) begin
            rdata_q <= rsp_rdata_i;
            rresp_q <= rsp_err_i ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_RD_RESP: begin
          if (rready_i && !is_last) begin
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            addr_q   <= next_addr;
          end
        end
        ST_WR_DATA: begin
          if (wvalid_i) begin
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
            // wlast must coincide exactly with the final counted beat.
            if (wlast_i != is_last) bresp_q <= worst_resp(bresp_q, RESP_SLVERR);
            if (flagged && !is_last) begin
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
              addr_q   <= next_addr;
            end
          end
        end
        ST_WR_WAIT: begin
          if (rsp_valid_i) begin
            if (rsp_err_i) bresp_q <= worst_resp(bresp_q, RESP_SLVERR);
            if (!is_last) begin
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
              addr_q   <= next_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign awready_o   = aw_gnt;
  assign arready_o   = ar_gnt;
  assign bid_o       = id_q;
  assign bresp_o     = bresp_q;
  assign bvalid_o    = bvalid_q;
  assign rid_o       = id_q;
  assign rdata_o     = rdata_q;
  assign rresp_o     = rresp_q;
  assign rvalid_o    = rvalid_q;
  assign rlast_o     = rvalid_q && is_last;
  assign req_addr_o  = addr_q;
  assign req_wdata_o = wdata_q;
  assign req_wstrb_o = wstrb_q;

endmodule
